// File: rtl/mp_fifo_sched.sv
// Round-robin scheduler feeding a 2-stage click FIFO over 2-phase drive/free, with credit tracking and owner-ID reporting on retire.
// Grant and drive follow the edge that samples a request; requests wait while a drive is unacknowledged or credits are exhausted.

module mp_fifo_sched_idq #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);
  assign dout_o  = mem_q[rd_q];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_ok) rd_q <= nxt(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module mp_fifo_sched #(
  parameter  int NREQ    = 4,
  parameter  int DEPTH   = 2,
  parameter  int IDW     = 2,
  parameter  int TIMEOUT = 64,
  localparam int CRW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_drive,
  input  logic            i_free,
  input  logic            i_driveNext,
  output logic            o_freeNext,
  output logic            o_done_vld,
  output logic [IDW-1:0]  o_done_id,
  output logic [CRW-1:0]  o_credits,
  output logic            o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDW:0] NREQ_L = (IDW + 1)'(NREQ);

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            drive_q, drive_d;
  logic            free_next_q, free_next_d;
  logic            done_vld_q, done_vld_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [CRW-1:0]  credits_q, credits_d;
  logic            err_q, err_d;

  logic free_s1_q, free_s_q, dn_s1_q, dn_s_q, dn_d_q;

  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off, win_id;
  logic [IDW:0]      sum;
  logic              issue, retire, retire_ok;
  logic              idq_empty;
  logic [IDW-1:0]    idq_head;

  // Rotate requests so the pointer sits at bit 0; the lowest set bit is the winner's offset.
  assign req2 = {i_req, i_req};
  always_comb begin
    rot = NREQ'(req2 >> ptr_q);
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDW'(j);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NREQ_L) sum = sum - NREQ_L;
    win_id = sum[IDW-1:0];
  end

  assign issue     = (state_q == IDLE) && (|i_req) && (credits_q != '0);
  assign retire    = dn_s_q ^ dn_d_q;
  assign retire_ok = retire && !idq_empty;

  mp_fifo_sched_idq #(.W(IDW), .DEPTH(DEPTH)) u_idq (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (issue),
    .din_i  (win_id),
    .pop_i  (retire_ok),
    .dout_o (idq_head),
    .empty_o(idq_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    drive_d     = drive_q;
    free_next_d = free_next_q ^ retire;
    done_vld_d  = retire_ok;
    done_id_d   = retire_ok ? idq_head : done_id_q;
    credits_d   = credits_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          gnt_d   = NREQ'(1) << win_id;
          drive_d = ~drive_q;
          ptr_d   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (free_s_q == drive_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (cnt_q != TW'(TIMEOUT)) cnt_d = cnt_q + TW'(1);
          if (cnt_d == TW'(TIMEOUT)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A retire with no recorded owner is a protocol violation from the FIFO side.
    if (retire && !retire_ok) err_d = 1'b1;
    case ({issue, retire_ok})
      2'b10: credits_d = credits_q - CRW'(1);
      2'b01: begin
        if (credits_q == CRW'(DEPTH)) err_d = 1'b1;
        else credits_d = credits_q + CRW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      drive_q     <= 1'b0;
      free_next_q <= 1'b0;
      done_vld_q  <= 1'b0;
      done_id_q   <= '0;
      credits_q   <= CRW'(DEPTH);
      err_q       <= 1'b0;
      free_s1_q   <= 1'b0;
      free_s_q    <= 1'b0;
      dn_s1_q     <= 1'b0;
      dn_s_q      <= 1'b0;
      dn_d_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      drive_q     <= drive_d;
      free_next_q <= free_next_d;
      done_vld_q  <= done_vld_d;
      done_id_q   <= done_id_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
      free_s1_q   <= i_free;
      free_s_q    <= free_s1_q;
      dn_s1_q     <= i_driveNext;
      dn_s_q      <= dn_s1_q;
      dn_d_q      <= dn_s_q;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_drive    = drive_q;
  assign o_freeNext = free_next_q;
  assign o_done_vld = done_vld_q;
  assign o_done_id  = done_id_q;
  assign o_credits  = credits_q;
  assign o_err      = err_q;
endmodule

// File: tb/tb_mp_fifo_sched.sv
// Bench for mp_fifo_sched: a behavioural click-FIFO environment plus a round-robin/credit reference model.
module tb_mp_fifo_sched;
  localparam int NREQ = 4, DEPTH = 2, IDW = 2, TIMEOUT = 64;
  localparam int CRW = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] i_req, o_gnt;
  logic            o_drive, i_free, i_driveNext, o_freeNext, o_done_vld, o_err;
  logic [IDW-1:0]  o_done_id;
  logic [CRW-1:0]  o_credits;

  int n_vec = 0, n_miss = 0;
  int free_dly, drain_dly, f_cnt, acc_c, dr_c;
  bit drain_en;
  int m_ptr, m_out, m_gr;
  int m_q[$];

  always #5 clk = ~clk;

  mp_fifo_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_gnt(o_gnt), .o_drive(o_drive),
    .i_free(i_free), .i_driveNext(i_driveNext), .o_freeNext(o_freeNext),
    .o_done_vld(o_done_vld), .o_done_id(o_done_id), .o_credits(o_credits), .o_err(o_err)
  );

  function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Accepts a token free_dly cycles after each drive; emits tokens drain_dly cycles apart once acknowledged.
  task automatic fifo_env();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_free = 1'b0; i_driveNext = 1'b0; f_cnt = 0; acc_c = 0; dr_c = 0;
      end else begin
        if (o_drive !== i_free) begin
          if (acc_c >= free_dly) begin i_free = o_drive; acc_c = 0; f_cnt++; end
          else acc_c++;
        end
        if (drain_en && f_cnt > 0 && o_freeNext === i_driveNext) begin
          if (dr_c >= drain_dly) begin i_driveNext = ~i_driveNext; f_cnt--; dr_c = 0; end
          else dr_c++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = '0; drain_en = 0; free_dly = 1; drain_dly = 0;
    repeat (3) @(negedge clk);
    m_ptr = 0; m_out = 0; m_gr = 0; m_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = '1;
    repeat (2) @(negedge clk);
    n_vec++; if (o_gnt !== 4'b0) begin n_miss++; $display("FAIL rst_gnt got=%b exp=0000", o_gnt); end
    n_vec++; if (o_drive !== 1'b0) begin n_miss++; $display("FAIL rst_drive got=%b exp=0", o_drive); end
    n_vec++; if (o_freeNext !== 1'b0) begin n_miss++; $display("FAIL rst_freeNext got=%b exp=0", o_freeNext); end
    n_vec++; if (o_done_vld !== 1'b0) begin n_miss++; $display("FAIL rst_done_vld got=%b exp=0", o_done_vld); end
    n_vec++; if (o_done_id !== 2'd0) begin n_miss++; $display("FAIL rst_done_id got=%0d exp=0", o_done_id); end
    n_vec++; if (o_credits !== CRW'(DEPTH)) begin n_miss++; $display("FAIL rst_credits got=%0d exp=%0d", o_credits, DEPTH); end
    n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL rst_err got=%b exp=0", o_err); end
  endtask

  task automatic test_single();
    int t, g2, nd;
    do_reset(); free_dly = 5; drain_en = 1; drain_dly = 2;
    i_req = 4'b0001;
    @(negedge clk);
    n_vec++; if (o_gnt !== 4'b0001) begin n_miss++; $display("FAIL single_gnt got=%b exp=0001", o_gnt); end
    n_vec++; if (o_drive !== 1'b1) begin n_miss++; $display("FAIL single_drive got=%b exp=1", o_drive); end
    n_vec++; if (o_credits !== CRW'(1)) begin n_miss++; $display("FAIL single_credits got=%0d exp=1", o_credits); end
    t = 1; g2 = -1; nd = 0;
    while ((g2 < 0 || nd < 2) && t < 80) begin
      @(negedge clk); t++;
      if (o_gnt !== 4'b0 && g2 < 0) begin
        g2 = t; i_req = '0;
        n_vec++; if (o_gnt !== 4'b0001) begin n_miss++; $display("FAIL single_gnt2 got=%b exp=0001", o_gnt); end
      end
      if (o_done_vld === 1'b1) begin
        nd++;
        n_vec++; if (o_done_id !== 2'd0) begin n_miss++; $display("FAIL single_done_id got=%0d exp=0", o_done_id); end
      end
    end
    n_vec++; if (g2 < 9 || g2 > 10) begin n_miss++; $display("FAIL single_ack_gap got=%0d exp=8..9 cycles", g2 - 1); end
    n_vec++; if (nd != 2) begin n_miss++; $display("FAIL single_dones got=%0d exp=2", nd); end
    repeat (3) @(negedge clk);
    n_vec++; if (o_credits !== CRW'(DEPTH)) begin n_miss++; $display("FAIL single_credits_end got=%0d exp=%0d", o_credits, DEPTH); end
  endtask

  task automatic test_rr_order();
    logic [NREQ-1:0] exp_g [5];
    int exp_id [5];
    int gi, di, t;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{0, 1, 2, 3, 0};
    do_reset(); free_dly = 1; drain_en = 1; drain_dly = 0;
    i_req = 4'b1111; gi = 0; di = 0; t = 0;
    while ((gi < 5 || di < 5) && t < 400) begin
      @(negedge clk); t++;
      if (o_gnt !== 4'b0 && gi < 5) begin
        n_vec++; if (o_gnt !== exp_g[gi]) begin n_miss++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", gi, o_gnt, exp_g[gi]); end
        gi++;
        if (gi == 5) i_req = '0;
      end
      if (o_done_vld === 1'b1 && di < 5) begin
        n_vec++; if (int'(o_done_id) != exp_id[di]) begin n_miss++; $display("FAIL rr_done_id[%0d] got=%0d exp=%0d", di, o_done_id, exp_id[di]); end
        di++;
      end
    end
    n_vec++; if (gi != 5 || di != 5) begin n_miss++; $display("FAIL rr_timeout grants=%0d dones=%0d exp=5/5", gi, di); end
    repeat (5) @(negedge clk);
    n_vec++; if (o_credits !== CRW'(DEPTH)) begin n_miss++; $display("FAIL rr_credits_end got=%0d exp=%0d", o_credits, DEPTH); end
  endtask

  task automatic test_no_drain();
    int ng, ndt;
    logic pd;
    do_reset(); free_dly = 2; drain_en = 0;
    i_req = 4'b1111; ng = 0; ndt = 0; pd = o_drive;
    repeat (100) begin
      @(negedge clk);
      if (o_gnt !== 4'b0) ng++;
      if (o_drive !== pd) begin ndt++; pd = o_drive; end
    end
    i_req = '0;
    n_vec++; if (ng != DEPTH) begin n_miss++; $display("FAIL nodrain_grants got=%0d exp=%0d", ng, DEPTH); end
    n_vec++; if (ndt != DEPTH) begin n_miss++; $display("FAIL nodrain_drive_toggles got=%0d exp=%0d", ndt, DEPTH); end
    n_vec++; if (o_credits !== CRW'(0)) begin n_miss++; $display("FAIL nodrain_credits got=%0d exp=0", o_credits); end
    n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL nodrain_err got=%b exp=0", o_err); end
  endtask

  task automatic test_same_cycle();
    do_reset(); free_dly = 1; drain_en = 0;
    i_req = 4'b0001;
    @(negedge clk); i_req = '0;
    repeat (10) @(negedge clk);
    n_vec++; if (o_credits !== CRW'(1)) begin n_miss++; $display("FAIL same_pre_credits got=%0d exp=1", o_credits); end
    i_driveNext = ~i_driveNext;
    @(negedge clk);
    @(negedge clk); i_req = 4'b0010;
    @(negedge clk); i_req = '0;
    n_vec++; if (o_gnt !== 4'b0010) begin n_miss++; $display("FAIL same_gnt got=%b exp=0010", o_gnt); end
    n_vec++; if (o_done_vld !== 1'b1) begin n_miss++; $display("FAIL same_done_vld got=%b exp=1", o_done_vld); end
    n_vec++; if (o_done_id !== 2'd0) begin n_miss++; $display("FAIL same_done_id got=%0d exp=0", o_done_id); end
    n_vec++; if (o_credits !== CRW'(1)) begin n_miss++; $display("FAIL same_credits got=%0d exp=1", o_credits); end
    n_vec++; if (o_freeNext !== 1'b1) begin n_miss++; $display("FAIL same_freeNext got=%b exp=1", o_freeNext); end
    @(negedge clk);
    n_vec++; if (o_done_vld !== 1'b0) begin n_miss++; $display("FAIL same_done_pulse got=%b exp=0", o_done_vld); end
    n_vec++; if (o_freeNext !== 1'b1) begin n_miss++; $display("FAIL same_freeNext_once got=%b exp=1", o_freeNext); end
  endtask

  task automatic test_timeout();
    do_reset(); free_dly = 100000; drain_en = 0;
    i_req = 4'b0001;
    @(negedge clk); i_req = '0;
    n_vec++; if (o_gnt !== 4'b0001) begin n_miss++; $display("FAIL to_gnt got=%b exp=0001", o_gnt); end
    repeat (61) @(negedge clk);
    n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL to_err_early got=%b exp=0", o_err); end
    repeat (4) @(negedge clk);
    n_vec++; if (o_err !== 1'b1) begin n_miss++; $display("FAIL to_err_set got=%b exp=1", o_err); end
    i_req = 4'b0100;
    repeat (30) @(negedge clk);
    n_vec++; if (o_err !== 1'b1) begin n_miss++; $display("FAIL to_err_sticky got=%b exp=1", o_err); end
    n_vec++; if (o_credits !== CRW'(1)) begin n_miss++; $display("FAIL to_no_regrant credits got=%0d exp=1", o_credits); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL to_async_err got=%b exp=0", o_err); end
    n_vec++; if (o_credits !== CRW'(DEPTH)) begin n_miss++; $display("FAIL to_async_credits got=%0d exp=%0d", o_credits, DEPTH); end
    n_vec++; if (o_drive !== 1'b0) begin n_miss++; $display("FAIL to_async_drive got=%b exp=0", o_drive); end
  endtask

  task automatic test_spurious();
    bit seen;
    do_reset(); drain_en = 0;
    @(negedge clk); i_driveNext = ~i_driveNext;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_done_vld === 1'b1) seen = 1;
    end
    n_vec++; if (seen) begin n_miss++; $display("FAIL spur_done_vld got=1 exp=0"); end
    n_vec++; if (o_err !== 1'b1) begin n_miss++; $display("FAIL spur_err got=%b exp=1", o_err); end
    n_vec++; if (o_credits !== CRW'(DEPTH)) begin n_miss++; $display("FAIL spur_credits got=%0d exp=%0d", o_credits, DEPTH); end
  endtask

  task automatic test_random();
    do_reset(); drain_en = 1;
    for (int seg = 0; seg < 3; seg++) begin
      free_dly = $urandom_range(0, 6); drain_dly = $urandom_range(0, 5);
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if (o_done_vld === 1'b1) begin
          if (m_q.size() == 0) begin
            n_vec++; n_miss++; $display("FAIL rnd_done_unexpected id=%0d exp=no retire", o_done_id);
          end else begin
            int e;
            e = m_q.pop_front(); m_out--;
            n_vec++; if (int'(o_done_id) != e) begin n_miss++; $display("FAIL rnd_done_id got=%0d exp=%0d", o_done_id, e); end
          end
        end
        if (o_gnt !== 4'b0) begin
          int w;
          logic [NREQ-1:0] eg;
          w = rr_pick(i_req, m_ptr);
          eg = (w >= 0) ? NREQ'(1) << w : '0;
          n_vec++; if (o_gnt !== eg) begin n_miss++; $display("FAIL rnd_gnt got=%b exp=%b req=%b", o_gnt, eg, i_req); end
          n_vec++; if (m_out >= DEPTH) begin n_miss++; $display("FAIL rnd_gnt_no_credit outstanding=%0d exp<%0d", m_out, DEPTH); end
          if (w >= 0) begin m_q.push_back(w); m_ptr = (w + 1) % NREQ; i_req[w] = 1'b0; end
          m_out++; m_gr++;
        end
        n_vec++; if (o_credits !== CRW'(DEPTH - m_out)) begin n_miss++; $display("FAIL rnd_credits got=%0d exp=%0d", o_credits, DEPTH - m_out); end
        n_vec++; if (o_drive !== m_gr[0]) begin n_miss++; $display("FAIL rnd_drive_parity got=%b exp=%b", o_drive, m_gr[0]); end
        if (c < 420) begin
          for (int k = 0; k < NREQ; k++) begin
            if (!i_req[k] && $urandom_range(0, 3) == 0) i_req[k] = 1'b1;
            else if (i_req[k] && $urandom_range(0, 31) == 0) i_req[k] = 1'b0;
          end
        end else i_req = '0;
      end
      n_vec++; if (o_credits !== CRW'(DEPTH)) begin n_miss++; $display("FAIL rnd_drained credits got=%0d exp=%0d", o_credits, DEPTH); end
    end
    n_vec++; if (o_err !== 1'b0) begin n_miss++; $display("FAIL rnd_err got=%b exp=0", o_err); end
  endtask

  initial begin
    rst_n = 1'b0; i_req = '0; i_free = 1'b0; i_driveNext = 1'b0;
    free_dly = 1; drain_dly = 0; drain_en = 0; f_cnt = 0; acc_c = 0; dr_c = 0;
    fork
      fifo_env();
    join_none
    test_reset();
    test_single();
    test_rr_order();
    test_no_drain();
    test_same_cycle();
    test_timeout();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
